// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter sharing one tagged FMA unit among NUM_REQ requesters.
// Tracks accepted-but-unreturned operations and routes results back by tag.
module fpu_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FLEN         = 64,
  parameter int TAG_WIDTH    = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*3*FLEN-1:0]   req_operands_i,
  input  logic [NUM_REQ*4-1:0]        req_op_i,
  input  logic [NUM_REQ-1:0]          req_op_mod_i,
  input  logic [NUM_REQ*3-1:0]        req_rnd_mode_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output logic [FLEN-1:0]             rsp_result_o,
  output logic [4:0]                  rsp_status_o,
  output logic                        fpu_in_valid_o,
  input  logic                        fpu_in_ready_i,
  output logic [3*FLEN-1:0]           fpu_operands_o,
  output logic [3:0]                  fpu_op_o,
  output logic                        fpu_op_mod_o,
  output logic [2:0]                  fpu_rnd_mode_o,
  output logic [TAG_WIDTH-1:0]        fpu_tag_o,
  input  logic                        fpu_out_valid_i,
  output logic                        fpu_out_ready_o,
  input  logic [FLEN-1:0]             fpu_result_i,
  input  logic [4:0]                  fpu_status_i,
  input  logic [TAG_WIDTH-1:0]        fpu_tag_i,
  input  logic                        flush_i,
  output logic                        fpu_flush_o,
  output logic                        busy_o
);

  localparam int CNT_W = 4;

  logic [CNT_W-1:0]     inflight_cnt;
  logic [TAG_WIDTH-1:0] rr_ptr;
  logic [TAG_WIDTH-1:0] gnt_idx;
  logic                 gnt_found;
  logic                 eligible;
  logic                 in_hs;
  logic                 out_hs;
  logic                 tag_ok;
  int                   scan_idx;

  // Saturating in-flight update: a stray return at zero must not wrap.
  function automatic logic [CNT_W-1:0] next_inflight(input logic [CNT_W-1:0] cnt,
                                                     input logic inc, input logic dec);
    if (inc && !dec) return cnt + CNT_W'(1);
    if (dec && !inc) return (cnt == '0) ? '0 : cnt - CNT_W'(1);
    return cnt;
  endfunction

  // Grant scan starts one past the last served requester and wraps.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_found && req_valid_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = TAG_WIDTH'(scan_idx);
      end
    end
  end

  assign eligible       = rst_ni && !flush_i && (inflight_cnt < CNT_W'(MAX_INFLIGHT));
  assign fpu_in_valid_o = eligible && gnt_found;
  assign in_hs          = fpu_in_valid_o && fpu_in_ready_i;
  assign req_ready_o    = in_hs ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign fpu_operands_o = req_operands_i[int'(gnt_idx)*3*FLEN +: 3*FLEN];
  assign fpu_op_o       = req_op_i[int'(gnt_idx)*4 +: 4];
  assign fpu_op_mod_o   = req_op_mod_i[gnt_idx];
  assign fpu_rnd_mode_o = req_rnd_mode_i[int'(gnt_idx)*3 +: 3];
  assign fpu_tag_o      = gnt_idx;

  assign tag_ok          = int'(fpu_tag_i) < NUM_REQ;
  assign fpu_out_ready_o = tag_ok && rsp_ready_i[fpu_tag_i];
  assign out_hs          = fpu_out_valid_i && fpu_out_ready_o;
  assign rsp_valid_o     = (fpu_out_valid_i && tag_ok && rst_ni && !flush_i)
                           ? (NUM_REQ'(1) << fpu_tag_i) : '0;
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;

  assign fpu_flush_o = flush_i;
  assign busy_o      = (inflight_cnt != '0);

  // Accounting state; pointer resets so requester 0 is served first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_cnt <= '0;
      rr_ptr       <= TAG_WIDTH'(NUM_REQ - 1);
    end else begin
      if (flush_i) inflight_cnt <= '0;
      else         inflight_cnt <= next_inflight(inflight_cnt, in_hs, out_hs);
      if (in_hs) rr_ptr <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Randomized bench for fpu_share_arbiter against an integer-level model of
// the arbitration, accounting and routing rules.
module tb_fpu_share_arbiter;

  localparam int NR = 4;
  localparam int FL = 64;
  localparam int TW = 2;
  localparam int MI = 4;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*3*FL-1:0] req_operands;
  logic [NR*4-1:0]   req_op;
  logic [NR-1:0]     req_op_mod;
  logic [NR*3-1:0]   req_rnd_mode;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [FL-1:0]     rsp_result;
  logic [4:0]        rsp_status;
  logic              fpu_in_valid;
  logic              fpu_in_ready;
  logic [3*FL-1:0]   fpu_operands;
  logic [3:0]        fpu_op;
  logic              fpu_op_mod;
  logic [2:0]        fpu_rnd_mode;
  logic [TW-1:0]     fpu_tag;
  logic              fpu_out_valid;
  logic              fpu_out_ready;
  logic [FL-1:0]     fpu_result;
  logic [4:0]        fpu_status;
  logic [TW-1:0]     fpu_tag_in;
  logic              flush;
  logic              fpu_flush;
  logic              busy;

  fpu_share_arbiter #(.NUM_REQ(NR), .FLEN(FL), .TAG_WIDTH(TW), .MAX_INFLIGHT(MI)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operands_i(req_operands), .req_op_i(req_op), .req_op_mod_i(req_op_mod),
    .req_rnd_mode_i(req_rnd_mode),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod),
    .fpu_rnd_mode_o(fpu_rnd_mode), .fpu_tag_o(fpu_tag),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
    .flush_i(flush), .fpu_flush_o(fpu_flush), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: last served requester and outstanding operation count.
  int m_ptr = NR - 1;
  int m_inf = 0;
  bit m_in_hs, m_out_hs;

  task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int pick_grant();
    for (int k = 1; k <= NR; k++) begin
      int idx = (m_ptr + k) % NR;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Compare every output against the model, then advance the model at the edge.
  task automatic cycle();
    int g;
    bit elig, inv;
    logic [NR-1:0] exp_rdy, exp_rsp;
    #1;
    g    = pick_grant();
    elig = rst_ni && !flush && (m_inf < MI);
    inv  = elig && (g >= 0);
    exp_rdy = (inv && fpu_in_ready) ? NR'(1 << g) : '0;
    exp_rsp = (rst_ni && !flush && fpu_out_valid) ? NR'(1 << fpu_tag_in) : '0;
    chk("in_valid", 192'(fpu_in_valid), 192'(inv));
    chk("req_ready", 192'(req_ready), 192'(exp_rdy));
    if (inv) begin
      chk("tag", 192'(fpu_tag), 192'(g));
      chk("operands", fpu_operands, req_operands[g*3*FL +: 3*FL]);
      chk("op", 192'({fpu_op, fpu_op_mod, fpu_rnd_mode}),
          192'({req_op[g*4 +: 4], req_op_mod[g], req_rnd_mode[g*3 +: 3]}));
    end
    chk("rsp_valid", 192'(rsp_valid), 192'(exp_rsp));
    chk("out_ready", 192'(fpu_out_ready), 192'(rsp_ready[fpu_tag_in]));
    chk("result", 192'({rsp_result, rsp_status}), 192'({fpu_result, fpu_status}));
    chk("flush_o", 192'(fpu_flush), 192'(flush));
    chk("busy", 192'(busy), 192'(rst_ni && m_inf != 0));
    m_in_hs  = inv && fpu_in_ready;
    m_out_hs = fpu_out_valid && rsp_ready[fpu_tag_in];
    @(posedge clk);
    if (!rst_ni) begin
      m_inf = 0; m_ptr = NR - 1;
    end else if (flush) begin
      m_inf = 0;
    end else begin
      if (m_in_hs) m_ptr = g;
      m_inf = m_inf + int'(m_in_hs) - int'(m_out_hs);
      if (m_inf < 0) m_inf = 0;
    end
    @(negedge clk);
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NR; i++) begin
      req_operands[i*3*FL +: 3*FL] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req_op[i*4 +: 4]             = 4'($urandom);
      req_op_mod[i]                = 1'($urandom);
      req_rnd_mode[i*3 +: 3]       = 3'($urandom);
    end
    fpu_result = {$urandom, $urandom};
    fpu_status = 5'($urandom);
  endtask

  task automatic random_cycle();
    randomize_payload();
    req_valid     = NR'($urandom);
    fpu_in_ready  = ($urandom_range(0, 3) != 0);
    fpu_out_valid = ($urandom_range(0, 2) == 0);
    fpu_tag_in    = TW'($urandom);
    rsp_ready     = NR'($urandom);
    flush         = ($urandom_range(0, 39) == 0);
    cycle();
  endtask

  int accepts;

  initial begin
    rst_ni = 1'b0; flush = 1'b0;
    req_valid = '1; fpu_in_ready = 1'b1; fpu_out_valid = 1'b1; fpu_tag_in = 2'd1;
    rsp_ready = '1;
    randomize_payload();
    @(negedge clk);
    repeat (2) cycle();
    rst_ni = 1'b1;

    // Saturate: four accepts round-robin from requester 0, then stall.
    fpu_out_valid = 1'b0;
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      randomize_payload();
      #1;
      if (req_ready != '0) accepts++;
      cycle();
    end
    chk("sat_accepts", 192'(accepts), 192'(4));
    chk("sat_busy", 192'(busy), 192'(1));

    // Response blocked by requester 2's ready, then released.
    fpu_out_valid = 1'b1; fpu_tag_in = 2'd2; rsp_ready = 4'b1011;
    cycle();
    rsp_ready = 4'b1111;
    cycle();
    fpu_out_valid = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();

    // Lone requester 3 held off by the FPU.
    req_valid = 4'b1000; fpu_in_ready = 1'b0;
    repeat (5) cycle();
    fpu_in_ready = 1'b1;
    cycle();

    repeat (3000) random_cycle();

    // Reset in the middle of traffic discards accounting.
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_in_valid", 192'(fpu_in_valid), 192'(0));
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_rsp_valid", 192'(rsp_valid), 192'(0));
    @(negedge clk);
    m_inf = 0; m_ptr = NR - 1;
    req_valid = '1;
    cycle();
    rst_ni = 1'b1;
    fpu_in_ready = 1'b1; flush = 1'b0; fpu_out_valid = 1'b0;
    cycle();
    repeat (500) random_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_share_arbiter.md
FPU_SHARE_ARBITER -- requirements
Module: fpu_share_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one FMA unit (2..8).
REQ-002 Parameter FLEN, default 64, operand/result width.
REQ-003 Parameter TAG_WIDTH, default 2, FPU tag width; SHALL equal clog2(NUM_REQ).
REQ-004 Parameter MAX_INFLIGHT, default 4, maximum accepted-but-unreturned operations (1..15).
REQ-005 clk_i  in  1  single clock, rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 req_valid_i  in  NUM_REQ  per-requester operation valid.
REQ-008 req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero).
REQ-009 req_operands_i  in  NUM_REQ*3*FLEN  three operands per requester, requester i at slice i.
REQ-010 req_op_i  in  NUM_REQ*4  FPU operation code per requester.
REQ-011 req_op_mod_i  in  NUM_REQ  operation modifier per requester.
REQ-012 req_rnd_mode_i  in  NUM_REQ*3  rounding mode per requester.
REQ-013 rsp_valid_o  out  NUM_REQ  per-requester result valid.
REQ-014 rsp_ready_i  in  NUM_REQ  per-requester result ready.
REQ-015 rsp_result_o  out  FLEN  shared result bus, meaningful only where rsp_valid_o set.
REQ-016 rsp_status_o  out  5  shared exception flags (NV,DZ,OF,UF,NX).
REQ-017 fpu_in_valid_o / fpu_in_ready_i  out/in  1  FPU input handshake.
REQ-018 fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o  out  3*FLEN,4,1,3  muxed from granted requester.
REQ-019 fpu_tag_o  out  TAG_WIDTH  index of granted requester.
REQ-020 fpu_out_valid_i / fpu_out_ready_o  in/out  1  FPU output handshake.
REQ-021 fpu_result_i, fpu_status_i, fpu_tag_i  in  FLEN,5,TAG_WIDTH  FPU result, flags, returned tag.
REQ-022 flush_i  in  1  drop all in-flight work; fpu_flush_o  out  1  equals flush_i combinationally.
REQ-023 busy_o  out  1  high while in-flight count nonzero.

Function
REQ-024 Arbitration round-robin: grant lowest index i at or cyclically after ptr+1 with req_valid_i[i] set.
REQ-025 Grant eligible only when inflight < MAX_INFLIGHT and flush_i low; otherwise req_ready_o all zero, fpu_in_valid_o low.
REQ-026 fpu_in_valid_o SHALL be high when any request valid and grant eligible; grant computed combinationally, zero added latency.
REQ-027 req_ready_o[g] = fpu_in_ready_i AND fpu_in_valid_o for granted g only; all other bits zero.
REQ-028 fpu_* payload and fpu_tag_o = g SHALL be driven from requester g; grant SHALL NOT depend on fpu_in_ready_i (no valid retraction).
REQ-029 ptr updates to g only on input handshake; held otherwise.
REQ-030 Response routing: rsp_valid_o[fpu_tag_i] = fpu_out_valid_i, other bits zero; fpu_out_ready_o = rsp_ready_i[fpu_tag_i]; result/status pass through combinationally.
REQ-031 inflight: +1 on input handshake, -1 on output handshake, unchanged when both same cycle.
REQ-032 Output handshake with inflight==0 and no input handshake is an error; inflight SHALL stay 0 (no underflow).
REQ-033 flush_i high: inflight cleared to 0 next edge regardless of handshakes; rsp_valid_o forced zero that cycle; ptr held.
REQ-034 busy_o = (inflight != 0), registered count, no combinational path from inputs.

Reset
REQ-035 Asynchronous assertion of rst_ni low SHALL set inflight 0, ptr NUM_REQ-1 (requester 0 first priority).
REQ-036 During reset req_ready_o, rsp_valid_o, fpu_in_valid_o, busy_o SHALL be 0; fpu_out_ready_o follows REQ-030.
REQ-037 Reset mid-operation discards all in-flight accounting; first post-reset grant follows REQ-035 pointer.

Verification
REQ-038 All four requesters valid continuously, fpu_in_ready_i=1, outputs drained -> grants 0,1,2,3,0,... one per cycle, tags match.
REQ-039 MAX_INFLIGHT=4, fpu_out_valid_i held 0 -> exactly 4 accepts, then fpu_in_valid_o low, busy_o=1; one return -> one further accept next cycle.
REQ-040 Return with fpu_tag_i=2, rsp_ready_i=4'b1011 -> rsp_valid_o=4'b0100, fpu_out_ready_o=0; raise rsp_ready_i[2] -> handshake, inflight decrements.
REQ-041 Simultaneous accept and return at inflight=3 -> inflight stays 3, busy_o stays 1.
REQ-042 inflight=3, assert flush_i one cycle -> no grant that cycle, inflight=0, busy_o=0 next cycle, fpu_flush_o pulses.
REQ-043 Only requester 3 valid, ptr=3, fpu_in_ready_i=0 for 5 cycles -> fpu_in_valid_o steady high, fpu_tag_o=3, req_ready_o=0 until ready.
